// File: rtl/sar_adc_sequencer.sv
// sar_adc_sequencer: paces SAR ADC conversions, averages 2^AVG_LOG2 results, one-deep valid/ready output.
//   clk, rst                      : clock, synchronous active-high reset
//   enable, period                : run control; conversion spacing is period+1 cycles
//   adc_start, adc_eoc, adc_dout  : ADC handshake (start pulse, end-of-conversion level, data)
//   sample, sample_valid/ready    : averaged result and its output handshake
//   overrun, timeout_err, clr_err : sticky error flags and their common clear
module sar_adc_sequencer #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 15,
    parameter int PER_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    output logic             adc_start,
    input  logic             adc_eoc,
    input  logic [7:0]       adc_dout,
    output logic [7:0]       sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    output logic             timeout_err,
    input  logic             clr_err
);
    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int WC_W  = $clog2(TIMEOUT + 1);
    localparam logic [AVG_LOG2:0] NCONV = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

    typedef enum logic [1:0] {IDLE, START, WAIT, EMIT} state_t;

    state_t            state;
    logic [PER_W-1:0]  rc;
    logic              pending;
    logic [WC_W-1:0]   wcnt;
    logic [ACC_W-1:0]  acc;
    logic [AVG_LOG2:0] cnt;
    logic              tick;
    logic [AVG_LOG2:0] cnt_inc;
    logic [ACC_W-1:0]  acc_sum;
    logic [7:0]        avg;
    logic              take;

    // >= rather than == so a period lowered mid-count wraps at once instead of running to 2^PER_W
    assign tick    = enable && rc >= period;
    assign cnt_inc = cnt + 1'b1;
    assign acc_sum = acc + ACC_W'(adc_dout);
    assign avg     = 8'(acc >> AVG_LOG2);
    // the output register can accept a result if empty or being drained this cycle
    assign take    = !sample_valid || sample_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rc           <= '0;
            pending      <= 1'b0;
            wcnt         <= '0;
            acc          <= '0;
            cnt          <= '0;
            adc_start    <= 1'b0;
            sample       <= 8'h00;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            rc          <= (!enable || tick) ? '0 : rc + 1'b1;
            adc_start   <= 1'b0;
            overrun     <= overrun && !clr_err;
            timeout_err <= timeout_err && !clr_err;
            if (sample_valid && sample_ready)
                sample_valid <= 1'b0;
            if (tick)
                pending <= 1'b1;
            // later assignments below override: entering START clears pending, set events beat clr_err
            case (state)
                IDLE: begin
                    if (!enable) begin
                        acc     <= '0;
                        cnt     <= '0;
                        pending <= 1'b0;
                    end else if (pending) begin
                        pending   <= 1'b0;
                        adc_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (adc_eoc) begin
                        acc   <= acc_sum;
                        cnt   <= cnt_inc;
                        state <= (cnt_inc == NCONV) ? EMIT : IDLE;
                    end else if (wcnt == WC_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                EMIT: begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= IDLE;
                    if (take) begin
                        sample       <= avg;
                        sample_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_adc_sequencer.sv
// tb_sar_adc_sequencer: directed checks of sar_adc_sequencer (AVG_LOG2=0 and AVG_LOG2=2 instances).
module tb_sar_adc_sequencer;
    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] period = 16'd20;
    logic        ready = 1'b0;
    logic        clr_err = 1'b0;
    logic        mute = 1'b0;

    logic        en0 = 1'b0, start0, eoc0 = 1'b0, valid0, ovr0, to0;
    logic [7:0]  dout0 = 8'h00, sample0;
    logic        en2 = 1'b0, start2, eoc2 = 1'b0, valid2, ovr2, to2;
    logic [7:0]  dout2 = 8'h00, sample2;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int cd0 = 0, cd2 = 0;
    logic [7:0] q0[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_adc_sequencer #(.AVG_LOG2(0)) u0 (
        .clk(clk), .rst(rst), .enable(en0), .period(period),
        .adc_start(start0), .adc_eoc(eoc0), .adc_dout(dout0),
        .sample(sample0), .sample_valid(valid0), .sample_ready(ready),
        .overrun(ovr0), .timeout_err(to0), .clr_err(clr_err)
    );

    sar_adc_sequencer u2 (
        .clk(clk), .rst(rst), .enable(en2), .period(period),
        .adc_start(start2), .adc_eoc(eoc2), .adc_dout(dout2),
        .sample(sample2), .sample_valid(valid2), .sample_ready(ready),
        .overrun(ovr2), .timeout_err(to2), .clr_err(clr_err)
    );

    // ADC models: eoc for one cycle after LAT WAIT cycles, data popped from a queue
    always @(posedge clk) begin
        eoc0 <= 1'b0;
        if (rst) cd0 <= 0;
        else if (start0) cd0 <= LAT;
        else if (cd0 > 0) begin
            cd0 <= cd0 - 1;
            if (cd0 == 1) begin
                eoc0 <= 1'b1;
                if (q0.size() > 0) dout0 <= q0.pop_front();
                else dout0 <= 8'h00;
            end
        end
    end

    always @(posedge clk) begin
        eoc2 <= 1'b0;
        if (rst) cd2 <= 0;
        else if (start2) cd2 <= LAT;
        else if (cd2 > 0) begin
            cd2 <= cd2 - 1;
            if (cd2 == 1 && !mute) begin
                eoc2 <= 1'b1;
                if (q2.size() > 0) dout2 <= q2.pop_front();
                else dout2 <= 8'h00;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return start0;
            1: return start2;
            2: return valid2;
            3: return eoc2;
            default: return ovr2;
        endcase
    endfunction

    task automatic wait_for(input int k, input int lim, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sig(k) && n < lim);
        chk(tag, 32'(sig(k)), 32'd1);
    endtask

    task automatic quiesce();
        en2 = 1'b0;
        ready = 1'b1;
        mute = 1'b0;
        repeat (30) step();
        q2.delete();
    endtask

    initial begin
        int s, s2, n, starts;
        repeat (3) step();
        chk("rst_start", 32'(start2), 32'd0);
        chk("rst_sample", 32'(sample2), 32'h00);
        chk("rst_valid", 32'(valid2), 32'd0);
        chk("rst_overrun", 32'(ovr2), 32'd0);
        chk("rst_timeout", 32'(to2), 32'd0);
        chk("rst_valid0", 32'(valid0), 32'd0);
        rst = 1'b0;

        // single conversion, AVG_LOG2=0, period 20
        q0.push_back(8'hA5);
        q0.push_back(8'hA5);
        en0 = 1'b1;
        wait_for(0, 40, "single_start");
        s = cyc;
        step();
        chk("start_one_cycle", 32'(start0), 32'd0);
        repeat (9) step();
        chk("single_valid_early", 32'(valid0), 32'd0);
        step();
        chk("single_valid", 32'(valid0), 32'd1);
        chk("single_sample", 32'(sample0), 32'hA5);
        ready = 1'b1;
        step();
        chk("single_transfer", 32'(valid0), 32'd0);
        wait_for(0, 30, "single_start2");
        chk("single_spacing", 32'(cyc - s), 32'd21);
        en0 = 1'b0;
        ready = 1'b0;
        repeat (20) step();

        // averaging, AVG_LOG2=2
        ready = 1'b0;
        foreach (q2[i]) q2.delete(i);
        q2.push_back(8'h10);
        q2.push_back(8'h11);
        q2.push_back(8'h12);
        q2.push_back(8'h14);
        en2 = 1'b1;
        n = 0;
        starts = 0;
        do begin
            step();
            n++;
            if (start2) starts++;
        end while (!valid2 && n < 200);
        chk("avg_valid", 32'(valid2), 32'd1);
        chk("avg_starts", 32'(starts), 32'd4);
        chk("avg_sample", 32'(sample2), 32'h11);
        repeat (4) q2.push_back(8'hFF);
        ready = 1'b1;
        step();
        chk("avg_transfer", 32'(valid2), 32'd0);
        ready = 1'b0;
        wait_for(2, 200, "ff_valid");
        chk("ff_sample", 32'(sample2), 32'hFF);

        // backpressure: FF held, next result dropped
        repeat (4) q2.push_back(8'h20);
        wait_for(4, 200, "ovr_seen");
        chk("ovr_sample_held", 32'(sample2), 32'hFF);
        chk("ovr_valid_held", 32'(valid2), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovr_cleared", 32'(ovr2), 32'd0);
        repeat (4) q2.push_back(8'h30);
        repeat (4) wait_for(3, 40, "bp_eoc");
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("emit_accept_valid", 32'(valid2), 32'd1);
        chk("emit_accept_sample", 32'(sample2), 32'h30);
        chk("emit_accept_ovr", 32'(ovr2), 32'd0);

        // timeout
        quiesce();
        mute = 1'b1;
        en2 = 1'b1;
        wait_for(1, 40, "to_start");
        s = cyc;
        repeat (15) step();
        chk("to_not_yet", 32'(to2), 32'd0);
        step();
        chk("to_set", 32'(to2), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("to_cleared", 32'(to2), 32'd0);
        wait_for(1, 40, "to_start2");
        s2 = cyc;
        chk("to_restart_spacing", 32'(s2 - s), 32'd21);
        repeat (15) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("to_set_beats_clr", 32'(to2), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("to_cleared2", 32'(to2), 32'd0);
        mute = 1'b0;
        repeat (4) q2.push_back(8'h40);
        wait_for(1, 40, "to_start3");
        chk("to_restart_spacing2", 32'(cyc - s2), 32'd21);
        wait_for(2, 200, "to_recover_valid");
        chk("to_recover_sample", 32'(sample2), 32'h40);

        // period 0 overload
        quiesce();
        period = 16'd0;
        repeat (4) q2.push_back(8'h50);
        en2 = 1'b1;
        wait_for(1, 10, "p0_start");
        s = cyc;
        wait_for(1, 20, "p0_start2");
        chk("p0_spacing", 32'(cyc - s), 32'(3 + LAT));
        s = cyc;
        wait_for(1, 20, "p0_start3");
        chk("p0_spacing2", 32'(cyc - s), 32'(3 + LAT));
        wait_for(2, 40, "p0_valid");
        chk("p0_sample", 32'(sample2), 32'h50);
        wait_for(1, 20, "p0_no_lockup");

        // disable mid-average
        quiesce();
        period = 16'd20;
        q2.push_back(8'h80);
        q2.push_back(8'h80);
        en2 = 1'b1;
        wait_for(3, 60, "dis_eoc1");
        wait_for(3, 60, "dis_eoc2");
        en2 = 1'b0;
        repeat (5) step();
        repeat (4) q2.push_back(8'h20);
        en2 = 1'b1;
        wait_for(2, 200, "dis_valid");
        ready = 1'b0;
        chk("dis_fresh_sample", 32'(sample2), 32'h20);

        // reset during WAIT
        mute = 1'b1;
        wait_for(1, 40, "rst_pre_start");
        repeat (16) step();
        chk("rst_pre_to", 32'(to2), 32'd1);
        wait_for(1, 40, "rst_wait_start");
        repeat (3) step();
        chk("rst_pre_valid", 32'(valid2), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_start", 32'(start2), 32'd0);
        chk("mid_rst_sample", 32'(sample2), 32'h00);
        chk("mid_rst_valid", 32'(valid2), 32'd0);
        chk("mid_rst_overrun", 32'(ovr2), 32'd0);
        chk("mid_rst_timeout", 32'(to2), 32'd0);
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
